// File: rtl/irq_ctrl.sv
// Interrupt controller: per-source sync, edge/level latching, masking and fixed priority
// behind a 4-word register file. Define IRQ_NESTING_EN to allow higher-priority preemption.
module irq_ctrl #(
  parameter int N_SRC       = 6,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_SRC-1:0] src,
  input  logic [1:0]       addr,
  input  logic             we,
  input  logic [31:0]      din,
  output logic [31:0]      dout,
  output logic             irq_out,
  output logic [2:0]       irq_id,
  input  logic             int_ack
);

  typedef enum logic [1:0] {IDLE, REQ, SVC} state_t;

  localparam logic [1:0] A_PEND = 2'd0;
  localparam logic [1:0] A_MASK = 2'd1;
  localparam logic [1:0] A_MODE = 2'd2;
  localparam logic [1:0] A_ISR  = 2'd3;

`ifdef IRQ_NESTING_EN
  localparam bit NEST_EN = 1'b1;
`else
  localparam bit NEST_EN = 1'b0;
`endif

  state_t           state_q, state_d;
  logic [N_SRC-1:0] pend_q, pend_d;
  logic [N_SRC-1:0] mask_q, mask_d;
  logic [N_SRC-1:0] mode_q, mode_d;
  logic [N_SRC-1:0] isr_q, isr_d;
  logic [N_SRC-1:0] s_prev_q;
  logic [N_SRC-1:0] s;
  logic [N_SRC-1:0] edge_clr;
  logic             irq_out_q, irq_out_d;
  logic [2:0]       irq_id_q, irq_id_d;
  logic             cand_vld;
  logic [2:0]       cand;
  logic [2:0]       isr_top;
  logic             eligible;
  logic             eoi;
  logic             unused_din;

  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign s = src;
    end else begin : g_sync
      logic [N_SRC-1:0] sync_q [SYNC_STAGES];
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
        end else begin
          sync_q[0] <= src;
          for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
      end
      assign s = sync_q[SYNC_STAGES-1];
    end
  endgenerate

  assign unused_din = ^din[31:N_SRC];

  // Highest-index pending+enabled source wins; highest in-service bit is the EOI target.
  always_comb begin
    cand_vld = 1'b0;
    cand     = '0;
    isr_top  = '0;
    for (int i = 0; i < N_SRC; i++) begin
      if (pend_q[i] && mask_q[i]) begin
        cand_vld = 1'b1;
        cand     = 3'(i);
      end
      if (isr_q[i]) isr_top = 3'(i);
    end
  end

  assign eligible = cand_vld && ((isr_q == '0) || (NEST_EN && (cand > isr_top)));
  assign eoi      = we && (addr == A_ISR) && (isr_q != '0);

  always_comb begin
    state_d   = state_q;
    irq_out_d = irq_out_q;
    irq_id_d  = irq_id_q;
    isr_d     = isr_q;
    mask_d    = (we && addr == A_MASK) ? din[N_SRC-1:0] : mask_q;
    mode_d    = (we && addr == A_MODE) ? din[N_SRC-1:0] : mode_q;
    edge_clr  = (we && addr == A_PEND) ? din[N_SRC-1:0] : '0;
    if (eoi) isr_d[isr_top] = 1'b0;

    case (state_q)
      IDLE: begin
        if (eligible) begin
          state_d   = REQ;
          irq_out_d = 1'b1;
          irq_id_d  = cand;
        end
      end
      REQ: begin
        // Ack acts on the ID the CPU saw, i.e. the registered one.
        if (int_ack) begin
          state_d            = SVC;
          irq_out_d          = 1'b0;
          isr_d[irq_id_q]    = 1'b1;
          edge_clr[irq_id_q] = 1'b1;
        end else if (!eligible) begin
          state_d   = (isr_q == '0) ? IDLE : SVC;
          irq_out_d = 1'b0;
        end else begin
          irq_id_d = cand;
        end
      end
      SVC: begin
        irq_out_d = 1'b0;
        if (NEST_EN && eligible && !eoi) begin
          state_d   = REQ;
          irq_out_d = 1'b1;
          irq_id_d  = cand;
        end else if (isr_d == '0) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d   = IDLE;
        irq_out_d = 1'b0;
      end
    endcase

    // Edge bits: rising edge sets and outranks any clear; level bits follow s.
    pend_d = (mode_q & ((pend_q & ~edge_clr) | (s & ~s_prev_q))) | (~mode_q & s);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      pend_q    <= '0;
      mask_q    <= '0;
      mode_q    <= '0;
      isr_q     <= '0;
      s_prev_q  <= '0;
      irq_out_q <= 1'b0;
      irq_id_q  <= '0;
    end else begin
      state_q   <= state_d;
      pend_q    <= pend_d;
      mask_q    <= mask_d;
      mode_q    <= mode_d;
      isr_q     <= isr_d;
      s_prev_q  <= s;
      irq_out_q <= irq_out_d;
      irq_id_q  <= irq_id_d;
    end
  end

  always_comb begin
    dout = '0;
    case (addr)
      A_PEND:  dout[N_SRC-1:0] = pend_q;
      A_MASK:  dout[N_SRC-1:0] = mask_q;
      A_MODE:  dout[N_SRC-1:0] = mode_q;
      default: dout[N_SRC-1:0] = isr_q;
    endcase
  end

  assign irq_out = irq_out_q;
  assign irq_id  = irq_id_q;

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed bench for irq_ctrl: per-cycle vector table plus hand sequences for
// nesting/preemption and asynchronous reset during service.
module tb_irq_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [5:0]  src = '0;
  logic [1:0]  addr = '0;
  logic        we = 1'b0;
  logic [31:0] din = '0;
  logic        int_ack = 1'b0;
  logic [31:0] dout;
  logic        irq_out;
  logic [2:0]  irq_id;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  irq_ctrl #(.N_SRC(6), .SYNC_STAGES(2)) dut (
    .clk     (clk),
    .reset   (reset),
    .src     (src),
    .addr    (addr),
    .we      (we),
    .din     (din),
    .dout    (dout),
    .irq_out (irq_out),
    .irq_id  (irq_id),
    .int_ack (int_ack)
  );

  typedef struct {
    logic [5:0]  src;
    logic        we;
    logic [1:0]  wa;
    logic [31:0] wd;
    logic        ack;
    logic [1:0]  ra;
    logic [31:0] exp_dout;
    logic        exp_irq;
    logic [2:0]  exp_id;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic [5:0] s, input logic w, input logic [1:0] wa,
                     input logic [31:0] wd, input logic k, input logic [1:0] ra,
                     input logic [31:0] ed, input logic ei, input logic [2:0] eid);
    vec_t v;
    v.src = s; v.we = w; v.wa = wa; v.wd = wd; v.ack = k;
    v.ra = ra; v.exp_dout = ed; v.exp_irq = ei; v.exp_id = eid;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs; returns 1ns after the capturing edge.
  task automatic cycle(input logic [5:0] s, input logic w, input logic [1:0] a,
                       input logic [31:0] d, input logic k);
    src = s; we = w; addr = a; din = d; int_ack = k;
    @(posedge clk);
    #1;
    we = 1'b0;
    int_ack = 1'b0;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    cycle('0, 1'b1, a, d, 1'b0);
  endtask

  task automatic rd_check(input string name, input logic [1:0] a, input logic [31:0] exp);
    addr = a;
    #1;
    check(name, dout, exp);
  endtask

  task automatic wait_irq(input int max, input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < max && !ok; i++) begin
      cycle('0, 1'b0, 2'd0, '0, 1'b0);
      ok = irq_out;
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: irq_out never rose within %0d cycles (got 0, expected 1)", name, max);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    bit seen;

    // Test 1: single edge source, ack, EOI
    add(6'h00, 1, 2'd1, 32'h3F, 0, 2'd1, 32'h3F, 0, 0);
    add(6'h00, 1, 2'd2, 32'h01, 0, 2'd2, 32'h01, 0, 0);
    add(6'h01, 0, 2'd0, 32'h00, 0, 2'd0, 32'h00, 0, 0);
    add(6'h00, 0, 2'd0, 32'h00, 0, 2'd0, 32'h00, 0, 0);
    add(6'h00, 0, 2'd0, 32'h00, 0, 2'd0, 32'h01, 0, 0);
    add(6'h00, 0, 2'd0, 32'h00, 0, 2'd0, 32'h01, 1, 0);
    add(6'h00, 0, 2'd0, 32'h00, 1, 2'd3, 32'h01, 0, 0);
    add(6'h00, 0, 2'd0, 32'h00, 0, 2'd0, 32'h00, 0, 0);
    add(6'h00, 1, 2'd3, 32'h00, 0, 2'd3, 32'h00, 0, 0);
    add(6'h00, 0, 2'd0, 32'h00, 0, 2'd3, 32'h00, 0, 0);
    // Test 2: src0 and src2 rise together, priority then EOI
    add(6'h00, 1, 2'd2, 32'h05, 0, 2'd2, 32'h05, 0, 0);
    add(6'h05, 0, 2'd0, 32'h00, 0, 2'd0, 32'h00, 0, 0);
    add(6'h00, 0, 2'd0, 32'h00, 0, 2'd0, 32'h00, 0, 0);
    add(6'h00, 0, 2'd0, 32'h00, 0, 2'd0, 32'h05, 0, 0);
    add(6'h00, 0, 2'd0, 32'h00, 0, 2'd0, 32'h05, 1, 2);
    add(6'h00, 0, 2'd0, 32'h00, 1, 2'd3, 32'h04, 0, 0);
    add(6'h00, 0, 2'd0, 32'h00, 0, 2'd0, 32'h01, 0, 0);
    add(6'h00, 1, 2'd3, 32'h00, 0, 2'd3, 32'h00, 0, 0);
    add(6'h00, 0, 2'd0, 32'h00, 0, 2'd0, 32'h01, 1, 0);
    add(6'h00, 0, 2'd0, 32'h00, 1, 2'd0, 32'h00, 0, 0);
    add(6'h00, 1, 2'd3, 32'h00, 0, 2'd3, 32'h00, 0, 0);
    add(6'h00, 0, 2'd0, 32'h00, 0, 2'd3, 32'h00, 0, 0);
    // Test 3: level src1 requested, masked before ack, then level drop
    add(6'h02, 0, 2'd0, 32'h00, 0, 2'd0, 32'h00, 0, 0);
    add(6'h02, 0, 2'd0, 32'h00, 0, 2'd0, 32'h00, 0, 0);
    add(6'h02, 0, 2'd0, 32'h00, 0, 2'd0, 32'h02, 0, 0);
    add(6'h02, 0, 2'd0, 32'h00, 0, 2'd0, 32'h02, 1, 1);
    add(6'h02, 1, 2'd1, 32'h3D, 0, 2'd1, 32'h3D, 1, 1);
    add(6'h02, 0, 2'd0, 32'h00, 0, 2'd3, 32'h00, 0, 0);
    add(6'h02, 0, 2'd0, 32'h00, 0, 2'd0, 32'h02, 0, 0);
    add(6'h00, 1, 2'd1, 32'h3F, 0, 2'd1, 32'h3F, 0, 0);
    add(6'h00, 0, 2'd0, 32'h00, 0, 2'd0, 32'h02, 1, 1);
    add(6'h00, 0, 2'd0, 32'h00, 0, 2'd0, 32'h00, 1, 1);
    add(6'h00, 0, 2'd0, 32'h00, 0, 2'd3, 32'h00, 0, 0);
    // Test 5: W1C alone clears, W1C with coincident edge keeps the bit
    add(6'h00, 1, 2'd1, 32'h00, 0, 2'd1, 32'h00, 0, 0);
    add(6'h01, 0, 2'd0, 32'h00, 0, 2'd0, 32'h00, 0, 0);
    add(6'h00, 0, 2'd0, 32'h00, 0, 2'd0, 32'h00, 0, 0);
    add(6'h00, 0, 2'd0, 32'h00, 0, 2'd0, 32'h01, 0, 0);
    add(6'h01, 0, 2'd0, 32'h00, 0, 2'd0, 32'h01, 0, 0);
    add(6'h00, 0, 2'd0, 32'h00, 0, 2'd0, 32'h01, 0, 0);
    add(6'h00, 1, 2'd0, 32'h01, 0, 2'd0, 32'h01, 0, 0);
    add(6'h00, 0, 2'd0, 32'h00, 0, 2'd0, 32'h01, 0, 0);
    add(6'h00, 1, 2'd0, 32'h01, 0, 2'd0, 32'h00, 0, 0);

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("reset irq_out", irq_out, 0);
    check("reset irq_id", irq_id, 0);
    rd_check("reset PEND", 2'd0, 0);
    rd_check("reset MASK", 2'd1, 0);
    rd_check("reset MODE", 2'd2, 0);
    rd_check("reset ISR", 2'd3, 0);
    @(posedge clk);
    #1;
    reset = 1'b1;

    foreach (vecs[i]) begin
      cycle(vecs[i].src, vecs[i].we, vecs[i].wa, vecs[i].wd, vecs[i].ack);
      addr = vecs[i].ra;
      #1;
      check($sformatf("vec%0d irq_out", i), irq_out, vecs[i].exp_irq);
      if (vecs[i].exp_irq) check($sformatf("vec%0d irq_id", i), irq_id, vecs[i].exp_id);
      check($sformatf("vec%0d dout[%0d]", i, vecs[i].ra), dout, vecs[i].exp_dout);
      $display("vec %0d: src=%h irq_out=%0b irq_id=%0d dout[%0d]=%h", i,
               vecs[i].src, irq_out, irq_id, vecs[i].ra, dout);
    end

    // Test 4: higher source arrives while src0 is in service
    wr(2'd1, 32'h3F);
    wr(2'd2, 32'h21);
    cycle(6'h01, 0, 2'd0, '0, 0);
    cycle(6'h00, 0, 2'd0, '0, 0);
    wait_irq(6, "t4 irq src0");
    check("t4 id src0", irq_id, 0);
    cycle('0, 0, 2'd0, '0, 1);
    rd_check("t4 ISR after ack0", 2'd3, 32'h01);
    cycle(6'h20, 0, 2'd0, '0, 0);
    cycle(6'h00, 0, 2'd0, '0, 0);
`ifdef IRQ_NESTING_EN
    wait_irq(6, "t4 nested irq src5");
    check("t4 nested id", irq_id, 5);
    cycle('0, 0, 2'd0, '0, 1);
    rd_check("t4 ISR nested", 2'd3, 32'h21);
    wr(2'd3, 0);
    rd_check("t4 ISR after EOI", 2'd3, 32'h01);
    wr(2'd3, 0);
    rd_check("t4 ISR after 2nd EOI", 2'd3, 32'h00);
`else
    seen = 1'b0;
    repeat (6) begin
      cycle('0, 0, 2'd0, '0, 0);
      if (irq_out) seen = 1'b1;
    end
    check("t4 irq held off", seen, 0);
    rd_check("t4 PEND src5", 2'd0, 32'h20);
    wr(2'd3, 0);
    rd_check("t4 ISR after EOI", 2'd3, 32'h00);
    wait_irq(6, "t4 irq src5 after EOI");
    check("t4 id src5", irq_id, 5);
    cycle('0, 0, 2'd0, '0, 1);
    rd_check("t4 ISR src5", 2'd3, 32'h20);
    wr(2'd3, 0);
    rd_check("t4 ISR final", 2'd3, 32'h00);
`endif
    $display("t4 done: irq_out=%0b", irq_out);

    // Test 6: asynchronous reset while in service
    cycle(6'h20, 0, 2'd0, '0, 0);
    cycle(6'h00, 0, 2'd0, '0, 0);
    wait_irq(6, "t6 irq src5");
    check("t6 id src5", irq_id, 5);
    cycle('0, 0, 2'd0, '0, 1);
    rd_check("t6 ISR in service", 2'd3, 32'h20);
    reset = 1'b0;
    #1;
    check("t6 reset irq_out", irq_out, 0);
    check("t6 reset irq_id", irq_id, 0);
    rd_check("t6 reset PEND", 2'd0, 0);
    rd_check("t6 reset MASK", 2'd1, 0);
    rd_check("t6 reset MODE", 2'd2, 0);
    rd_check("t6 reset ISR", 2'd3, 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b1;
    cycle('0, 0, 2'd0, '0, 0);
    check("t6 idle irq_out", irq_out, 0);
    wr(2'd1, 32'h01);
    wr(2'd2, 32'h01);
    cycle(6'h01, 0, 2'd0, '0, 0);
    cycle(6'h00, 0, 2'd0, '0, 0);
    wait_irq(6, "t6 irq after reset");
    check("t6 id after reset", irq_id, 0);
    $display("t6 done: irq_out=%0b irq_id=%0d", irq_out, irq_id);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
